twofish_round_seq: RTL
======================

Name: twofish_round_seq

Overview:
- Sequencer directly upstream of the control_d decoder in the Twofish datapath.
- Accepts a start request and generates the 5-bit step count x, one value per enabled cycle, from 0 to LAST. control_d decodes x into the whitening, mux and direction strobes.
- Also latches the encrypt/decrypt direction, produces the subkey round index, and signals busy and done to the top-level controller.

Parameters:
- CNT_W, 5, width of step counter x; must hold LAST.
- LAST, 19, final step value; the sequence is 0..LAST (20 steps).
- ROUND_FIRST, 2, value of x for Feistel round 0.
- ROUNDS, 16, number of Feistel rounds; round steps are ROUND_FIRST..ROUND_FIRST+ROUNDS-1.

Ports:
- CLK  in  1  single system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request to run one block; sampled only in IDLE.
- DEC_IN  in  1  direction for the requested block: 0 = encrypt, 1 = decrypt.
- KEY_RDY  in  1  key schedule valid; START is ignored while low.
- STEP_EN  in  1  advance enable while running; low = stall and hold all outputs.
- ABORT  in  1  synchronous cancel; highest priority after reset.
- x  out  CNT_W  current step count, fed to control_d.
- DEC  out  1  latched direction, fed to control_d/datapath.
- ROUND_IDX  out  4  subkey round index.
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle pulse when a block completes.

Behaviour:
- Reset (RST_N low, asynchronous): state = IDLE, x = 0, DEC = 0, BUSY = 0, DONE = 0. ROUND_IDX follows from x.
- States: IDLE, RUN.
- IDLE:
  - x is held at 0.
  - If START && KEY_RDY && !ABORT at a clock edge: latch DEC <= DEC_IN, go to RUN, x stays 0, BUSY = 1 from the next cycle.
  - If START is high while KEY_RDY is low, the request is dropped, not queued.
- RUN, STEP_EN high, x < LAST: x <= x + 1.
- RUN, STEP_EN high, x == LAST:
  - next state IDLE, x <= 0, BUSY <= 0, DONE <= 1 for exactly one cycle.
  - DONE is registered: it is high in the cycle after the last step is visible.
- RUN, STEP_EN low: x, DEC and state hold; DONE stays 0.
- Each step value is therefore visible for at least one full cycle. Latency from accepted START to DONE is LAST+2 cycles with STEP_EN held high: 21 cycles at defaults.
- START, DEC_IN and KEY_RDY are ignored in RUN. DEC cannot change mid-block.
- ABORT high at an edge in any state: state = IDLE, x = 0, BUSY = 0, DONE = 0.
  - ABORT overrides START and a final step in the same cycle.
  - DEC keeps its last latched value.
- ROUND_IDX (combinational from x and DEC):
  - For ROUND_FIRST <= x < ROUND_FIRST+ROUNDS: encrypt gives x - ROUND_FIRST; decrypt gives ROUND_FIRST+ROUNDS-1 - x.
  - Otherwise 0.
  - Width arithmetic: compute in CNT_W bits, truncate to 4.
- Counter never exceeds LAST and never wraps. A value > LAST is unreachable.
- A back-to-back START is accepted in the cycle where DONE is high, because state is already IDLE.
- Step map at defaults:
  - x = 0: load.
  - x = 1: input whitening.
  - x = 2..17: rounds 0..15.
  - x = 18: output whitening.
  - x = 19: store.

Test Plan:
- Reset mid-RUN (x = 7) by pulling RST_N low between edges -> x = 0, BUSY = 0, DONE = 0 immediately, without waiting for a clock edge.
- START = 1, DEC_IN = 0, KEY_RDY = 1, STEP_EN = 1 constant -> x = 0,1,…,19 on consecutive cycles; ROUND_IDX = 0..15 while x = 2..17; DONE high one cycle 21 cycles after START; BUSY then 0.
- Same run with DEC_IN = 1 -> DEC = 1 throughout; ROUND_IDX = 15 at x = 2 down to 0 at x = 17; toggling DEC_IN mid-run leaves DEC = 1.
- START with KEY_RDY = 0 -> stays IDLE, x = 0, BUSY = 0. STEP_EN low for 3 cycles at x = 5 -> x holds 5, then resumes at 6; DONE delayed by exactly 3 cycles.
- ABORT at x = 10 -> next cycle x = 0, BUSY = 0, no DONE. ABORT coincident with x = 19 -> DONE never asserts.
- START held high during the DONE cycle -> new block accepted; x restarts 0..19 with no idle gap beyond the DONE cycle.

Source files
------------

// File: rtl/twofish_round_seq.sv
// Step sequencer for the Twofish round datapath: walks x through 0..LAST once per
// accepted block, latching direction and deriving the subkey round index.
module twofish_round_seq #(
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned LAST        = 19,
  parameter int unsigned ROUND_FIRST = 2,
  parameter int unsigned ROUNDS      = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             DEC_IN,
  input  logic             KEY_RDY,
  input  logic             STEP_EN,
  input  logic             ABORT,
  output logic [CNT_W-1:0] x,
  output logic             DEC,
  output logic [3:0]       ROUND_IDX,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [CNT_W-1:0] LAST_X      = CNT_W'(LAST);
  localparam logic [CNT_W-1:0] RND_FIRST_X = CNT_W'(ROUND_FIRST);
  localparam logic [CNT_W-1:0] RND_LAST_X  = CNT_W'(ROUND_FIRST + ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic             dec_q, dec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      x_q     <= '0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; ABORT wins over START and over the final step
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    dec_d   = dec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (ABORT) begin
      state_d = IDLE;
      x_d     = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          x_d    = '0;
          busy_d = 1'b0;
          if (START && KEY_RDY) begin
            dec_d   = DEC_IN;
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
        RUN: begin
          if (STEP_EN) begin
            if (x_q == LAST_X) begin
              state_d = IDLE;
              x_d     = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              x_d = x_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          x_d     = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  logic [CNT_W-1:0] enc_off;
  logic [CNT_W-1:0] dec_off;

  // Round index counts up for encrypt and down for decrypt; zero outside round steps
  always_comb begin
    enc_off   = x_q - RND_FIRST_X;
    dec_off   = RND_LAST_X - x_q;
    ROUND_IDX = 4'd0;
    if ((x_q >= RND_FIRST_X) && (x_q <= RND_LAST_X)) begin
      ROUND_IDX = dec_q ? 4'(dec_off) : 4'(enc_off);
    end
  end

  assign x    = x_q;
  assign DEC  = dec_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
